pair_sequencer: RTL

- Issue-side controller for the acceleration pass. Each cycle it generates one (target i, source j) body-index pair for the position/mass RAMs that feed the pairwise-acceleration pipeline.
- It carries each pair's target index and valid bit down a fixed-length delay line. Two taps come out of that line:
  - an accumulate tap, aligned with the acceleration result, used to read the velocity RAM;
  - a write-back tap, aligned with the adder output, used to write the velocity RAM.
- It orders pairs so the same target is never reissued inside the velocity read-modify-write window, inserting bubbles for small body counts.

---
 rtl/pair_sequencer_if.sv | 33 +++
 rtl/pair_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pair_sequencer_if.sv
// Issue-side bus of the pair sequencer: pass control plus the three
// body-index streams (position read, accumulate tap, write-back tap).
interface pair_sequencer_if #(
    parameter int unsigned BODY_ADDR_WIDTH = 9
);
    logic                       start;
    logic                       abort;
    logic [BODY_ADDR_WIDTH:0]   num_bodies;
    logic                       busy;
    logic                       done;
    logic [BODY_ADDR_WIDTH-1:0] rd_i;
    logic [BODY_ADDR_WIDTH-1:0] rd_j;
    logic                       rd_valid;
    logic [BODY_ADDR_WIDTH-1:0] acc_i;
    logic                       acc_valid;
    logic [BODY_ADDR_WIDTH-1:0] wb_i;
    logic                       wb_valid;
    logic                       wb_last;

    // Pass controller side: requests passes, observes the index streams.
    modport master (
        output start, abort, num_bodies,
        input  busy, done, rd_i, rd_j, rd_valid,
        input  acc_i, acc_valid, wb_i, wb_valid, wb_last
    );

    // Sequencer side.
    modport slave (
        input  start, abort, num_bodies,
        output busy, done, rd_i, rd_j, rd_valid,
        output acc_i, acc_valid, wb_i, wb_valid, wb_last
    );
endinterface

// File: rtl/pair_sequencer.sv
// Pair sequencer: walks all (i, j) body pairs j-major, padding each row to
// at least RmwGap slots so a target index is never reissued inside the
// velocity read-modify-write window, and carries the target index down a
// delay line to the accumulate and write-back taps.
module pair_sequencer #(
    parameter int unsigned BODIES          = 512,
    parameter int unsigned BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int unsigned RamLatency      = 1,
    parameter int unsigned AcclLatency     = 123,
    parameter int unsigned AddTime         = 20,
    parameter int unsigned RmwGap          = 21
) (
    input  logic              clk,
    input  logic              rst,
    pair_sequencer_if.slave   bus
);

    localparam int unsigned AW      = BODY_ADDR_WIDTH;
    localparam int unsigned ACC_LAT = RamLatency + AcclLatency;
    localparam int unsigned DLAT    = ACC_LAT + AddTime;
    localparam int unsigned RMAX    = (BODIES > RmwGap) ? BODIES : RmwGap;
    localparam int unsigned CW0     = $clog2(RMAX + 1);
    localparam int unsigned W       = (CW0 > AW + 1) ? CW0 : AW + 1;
    localparam int unsigned DCW     = $clog2(DLAT + 1);

    localparam logic [W-1:0]   BODIES_W   = W'(BODIES);
    localparam logic [W-1:0]   GAP_W      = W'(RmwGap);
    localparam logic [W-1:0]   ONE_W      = W'(1);
    localparam logic [W-1:0]   TWO_W      = W'(2);
    localparam logic [DCW-1:0] CNT_ONE    = DCW'(1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DLAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   k_q, k_d;
    logic [W-1:0]   j_q, j_d;
    logic [W-1:0]   neff_q, neff_d;
    logic [W-1:0]   r_q, r_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           done_q, done_d;

    logic [W-1:0]   nb_w;
    logic [W-1:0]   neff_in;
    logic [W-1:0]   r_in;
    logic           pair_ok;
    logic           pair_last;
    logic [AW-1:0]  rd_i_w;
    logic           flush;

    logic [DLAT-1:0] vld_q;
    logic [DLAT-1:0] last_q;
    logic [AW-1:0]   idx_q [DLAT];

    // Clamp the requested body count and derive the padded row length.
    always_comb begin
        nb_w    = W'(bus.num_bodies);
        neff_in = (nb_w > BODIES_W) ? BODIES_W : nb_w;
        r_in    = (neff_in > GAP_W) ? neff_in : GAP_W;
    end

    // Current slot decode: a real pair, its target index and the last-pair mark.
    always_comb begin
        pair_ok   = (state_q == ISSUE) && (k_q < neff_q) && (k_q != j_q);
        pair_last = pair_ok && (k_q == neff_q - TWO_W) && (j_q == neff_q - ONE_W);
        rd_i_w    = pair_ok ? k_q[AW-1:0] : '0;
        flush     = bus.abort && (state_q != IDLE);
    end

    // Next-state logic for the pass FSM and slot counters.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        neff_d  = neff_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (neff_in >= TWO_W) begin
                        state_d = ISSUE;
                        neff_d  = neff_in;
                        r_d     = r_in;
                        k_d     = '0;
                        j_d     = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (k_q == r_q - ONE_W) begin
                    k_d = '0;
                    if (j_q == neff_q - ONE_W) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        j_d = j_q + ONE_W;
                    end
                end else begin
                    k_d = k_q + ONE_W;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort of a live pass overrides whatever the case above decided,
        // including the completion pulse on the final drain cycle.
        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            neff_q  <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            neff_q  <= neff_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Valid and last-pair marks along the delay line; cleared on reset or abort.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q[0]  <= pair_ok;
            last_q[0] <= pair_last;
            for (int unsigned s = 1; s < DLAT; s++) begin
                vld_q[s]  <= vld_q[s-1];
                last_q[s] <= last_q[s-1];
            end
        end
    end

    // Target indices along the delay line; qualified by the valid marks.
    always_ff @(posedge clk) begin
        idx_q[0] <= rd_i_w;
        for (int unsigned s = 1; s < DLAT; s++) begin
            idx_q[s] <= idx_q[s-1];
        end
    end

    // Output drive: read port from the slot decode, taps from the delay line.
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = done_q;
        bus.rd_valid  = pair_ok;
        bus.rd_i      = rd_i_w;
        bus.rd_j      = pair_ok ? j_q[AW-1:0] : '0;
        bus.acc_valid = vld_q[ACC_LAT-1];
        bus.acc_i     = vld_q[ACC_LAT-1] ? idx_q[ACC_LAT-1] : '0;
        bus.wb_valid  = vld_q[DLAT-1];
        bus.wb_i      = vld_q[DLAT-1] ? idx_q[DLAT-1] : '0;
        bus.wb_last   = vld_q[DLAT-1] & last_q[DLAT-1];
    end

endmodule
